// File: rtl/apb_rr_master.sv
// apb_rr_master -- round-robin APB master shared by N local requesters.
//
// Each requester holds req[i] with its address, write data and direction
// until it receives a one-cycle done[i]. The block picks one winner per
// IDLE cycle, runs the APB SETUP/ACCESS sequence for it, and returns the
// read data and error status with done.
//
// Optional feature macro: APB_RR_MASTER_TIMEOUT_EN
//   defined   : ACCESS is abandoned after TIMEOUT cycles without PREADY,
//               and done pulses with err=1, rdata=0.
//   undefined : ACCESS waits indefinitely for PREADY, and no counter is built.
//
// Ports:
//   PCLK, PRESETn            clock, asynchronous active-low reset
//   req, req_addr, req_wdata, req_write
//                            per-requester request, packed address/data, dir
//   gnt, done                one-hot grant (SETUP..last ACCESS), one-hot done
//   rdata, err               completion read data / error, valid with done
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA
//                            APB master outputs
//   PRDATA, PREADY, PSLVERR  APB slave responses
module apb_rr_master #(
    parameter int N       = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    input  logic [N-1:0]    req,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_wdata,
    input  logic [N-1:0]    req_write,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic [DW-1:0]   rdata,
    output logic            err,
    output logic            PSEL,
    output logic            PENABLE,
    output logic            PWRITE,
    output logic [AW-1:0]   PADDR,
    output logic [DW-1:0]   PWDATA,
    input  logic [DW-1:0]   PRDATA,
    input  logic            PREADY,
    input  logic            PSLVERR
);

    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q;
    logic [N-1:0]    gnt_q, done_q;
    logic [DW-1:0]   rdata_q, pwdata_q;
    logic [AW-1:0]   paddr_q;
    logic            pwrite_q, err_q;

    logic [N-1:0]    eligible;
    logic            hi_vld, lo_vld, win_vld;
    logic [PW-1:0]   hi_idx, lo_idx, win_idx;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;
    logic            win_write;
    logic            grant, xfer_end, timed_out;

    // Round-robin search. The requester just served is masked for the
    // IDLE cycle in which its done is high. The lowest eligible index
    // above the pointer wins; otherwise the lowest one at or below it.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no
        // path leaves one unassigned and no latch is inferred.
        eligible = req & ~done_q;
        hi_vld   = 1'b0;
        lo_vld   = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (eligible[j]) begin
                if (j > int'(ptr_q)) begin
                    hi_vld = 1'b1;
                    hi_idx = PW'(j);
                end else begin
                    lo_vld = 1'b1;
                    lo_idx = PW'(j);
                end
            end
        end
        win_vld = hi_vld | lo_vld;
        win_idx = hi_vld ? hi_idx : lo_idx;
    end

    // Select the winner's request fields from the packed buses.
    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_write = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (win_idx == PW'(j)) begin
                win_addr  = req_addr[j*AW +: AW];
                win_wdata = req_wdata[j*DW +: DW];
                win_write = req_write[j];
            end
        end
    end

`ifdef APB_RR_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;

    // Counts completed ACCESS cycles without PREADY; it is cleared outside ACCESS.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
        end else if (state_q == ST_ACCESS && !xfer_end) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign timed_out = (state_q == ST_ACCESS) && !PREADY &&
                       (cnt_q == CW'(TIMEOUT - 1));
`else
    // Without the timeout feature, TIMEOUT has no effect on the logic.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timed_out      = 1'b0;
`endif

    assign grant    = (state_q == ST_IDLE) && win_vld;
    assign xfer_end = (state_q == ST_ACCESS) && (PREADY || timed_out);

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!PRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (win_vld) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (xfer_end) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic: APB phase strobes are decoded from the state register.
    always_comb begin
        PSEL    = (state_q != ST_IDLE);
        PENABLE = (state_q == ST_ACCESS);
        PWRITE  = pwrite_q;
        PADDR   = paddr_q;
        PWDATA  = pwdata_q;
        gnt     = gnt_q;
        done    = done_q;
        rdata   = rdata_q;
        err     = err_q;
    end

    // Transfer datapath: the APB address/data are latched at grant and
    // stay untouched until the next grant, so they also hold through IDLE.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ptr_q    <= PW'(N - 1);
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else begin
            done_q <= '0;
            if (grant) begin
                ptr_q    <= win_idx;
                gnt_q    <= N'(1) << win_idx;
                paddr_q  <= win_addr;
                pwdata_q <= win_wdata;
                pwrite_q <= win_write;
            end
            if (xfer_end) begin
                gnt_q  <= '0;
                done_q <= gnt_q;
                if (timed_out) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end else begin
                    err_q   <= PSLVERR;
                    rdata_q <= pwrite_q ? '0 : PRDATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master -- self-checking bench for apb_rr_master (N=4).
// Requester drivers push expected completions into per-requester queues;
// a monitor pops and compares whenever done pulses. An APB slave model
// with a memory and random wait states answers the bus.
module tb_apb_rr_master;

    localparam int N       = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic            PCLK;
    logic            PRESETn;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_write;
    logic [N-1:0]    gnt, done;
    logic [DW-1:0]   rdata;
    logic            err;
    logic            PSEL, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [DW-1:0]   PRDATA;
    logic            PREADY, PSLVERR;

    apb_rr_master #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req(req), .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
        .gnt(gnt), .done(done), .rdata(rdata), .err(err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        int idx;
        int cyc;
    } log_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cycle    = 0;
    exp_t        exp_q[N][$];
    log_t        done_log[$];
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] slave_mem[logic [31:0]];
    logic [31:0] iss_addr[N];
    logic [31:0] iss_wdata[N];
    logic        iss_write[N];
    bit          pending[N];
    int          ahead[N];
    int          fixed_waits;
    bit          stall;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit is_err(input logic [31:0] a);
        return a[31:28] == 4'hE;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int k = 0; k < N; k++) if (v[k]) r = k;
        return r;
    endfunction

    // Raise a request and record the expected completion from the
    // transfer rules: writes return 0, reads return the last stored value,
    // error addresses set err and are not stored, timeouts give err=1/rdata=0.
    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input bit force_to, input bit push);
        exp_t e;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_write[i]          = w;
        req[i]                = 1'b1;
        iss_addr[i]           = a;
        iss_wdata[i]          = d;
        iss_write[i]          = w;
        pending[i]            = 1'b1;
        ahead[i]              = 0;
        if (push) begin
            e.err   = force_to ? 1'b1 : is_err(a);
            e.rdata = (w || force_to) ? 32'h0 : (model_mem.exists(a) ? model_mem[a] : 32'h0);
            if (w && !e.err) model_mem[a] = d;
            exp_q[i].push_back(e);
        end
    endtask

    task automatic wait_done(input int i, output int lat);
        lat = 0;
        do begin
            @(negedge PCLK);
            lat++;
        end while (!done[i] && lat < 100);
        if (!done[i]) check($sformatf("done_wait_req%0d", i), 96'(done[i]), 96'(1));
    endtask

    task automatic rr_driver(input int i);
        int lat;
        for (int k = 0; k < 2; k++) begin
            issue(i, 32'h200 + 32'(i * 16 + k * 4), $urandom, 1'b1, 1'b0, 1'b1);
            wait_done(i, lat);
        end
        req[i] = 1'b0;
    endtask

    task automatic rand_driver(input int i);
        int          lat;
        int          gap;
        logic [31:0] a;
        for (int k = 0; k < 6; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge PCLK);
            a = 32'((i + 1) * 4096) + 32'(4 * $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a[31:28] = 4'hE;
            issue(i, a, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            wait_done(i, lat);
            req[i] = 1'b0;
        end
    endtask

    task automatic run_counter();
        forever begin
            @(posedge PCLK);
            cycle++;
        end
    endtask

    // Scoreboard monitor: compares every completion against the queue of
    // its requester and bounds how many other transfers overtook it.
    task automatic run_monitor();
        exp_t e;
        log_t l;
        int   idx;
        forever begin
            @(posedge PCLK);
            #1;
            if (done != '0) begin
                check("done_onehot", 96'($onehot(done)), 96'(1));
                idx   = onehot_idx(done);
                l.idx = idx;
                l.cyc = cycle;
                done_log.push_back(l);
                if (exp_q[idx].size() == 0) begin
                    check("unexpected_done", 96'(done), 96'(0));
                end else begin
                    e = exp_q[idx].pop_front();
                    check($sformatf("rdata_req%0d", idx), 96'(rdata), 96'(e.rdata));
                    check($sformatf("err_req%0d", idx), 96'(err), 96'(e.err));
                end
                if (pending[idx]) check("rr_wait_bound", 96'(ahead[idx] <= N - 1), 96'(1));
                pending[idx] = 1'b0;
                for (int j = 0; j < N; j++) if (j != idx && pending[j]) ahead[j]++;
            end
        end
    endtask

    // APB slave model: drives responses at the falling edge and checks
    // that the bus carries the granted request and holds it through ACCESS.
    task automatic run_slave();
        int          waits;
        int          gi;
        logic [31:0] s_addr, s_wdata;
        logic        s_write;
        waits = 0;
        forever begin
            @(negedge PCLK);
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = 32'h0;
            if (PSEL && !PENABLE) begin
                waits   = (fixed_waits >= 0) ? fixed_waits : $urandom_range(0, 3);
                s_addr  = PADDR;
                s_wdata = PWDATA;
                s_write = PWRITE;
                gi      = onehot_idx(gnt);
                if (gi < 0) begin
                    check("gnt_in_setup", 96'(gnt), 96'(1));
                end else begin
                    check("paddr_setup", 96'(PADDR), 96'(iss_addr[gi]));
                    check("pwrite_setup", 96'(PWRITE), 96'(iss_write[gi]));
                    if (iss_write[gi]) check("pwdata_setup", 96'(PWDATA), 96'(iss_wdata[gi]));
                end
            end else if (PSEL && PENABLE) begin
                check("apb_stable", {31'h0, PWRITE, PWDATA, PADDR}, {31'h0, s_write, s_wdata, s_addr});
                if (!stall && waits == 0) begin
                    PREADY  = 1'b1;
                    PSLVERR = is_err(PADDR);
                    if (PWRITE) begin
                        if (!PSLVERR) slave_mem[PADDR] = PWDATA;
                    end else begin
                        PRDATA = slave_mem.exists(PADDR) ? slave_mem[PADDR] : 32'h0;
                    end
                end else if (waits > 0) begin
                    waits--;
                end
            end
        end
    endtask

    initial begin
        int lat;
        int n;
        PRESETn     = 1'b0;
        req         = '0;
        req_addr    = '0;
        req_wdata   = '0;
        req_write   = '0;
        PRDATA      = '0;
        PREADY      = 1'b0;
        PSLVERR     = 1'b0;
        fixed_waits = 0;
        stall       = 1'b0;
        fork
            run_counter();
            run_monitor();
            run_slave();
        join_none

        // Reset values, during and right after reset.
        repeat (3) @(negedge PCLK);
        check("reset_ctrl_in", {PSEL, PENABLE, PWRITE, err, gnt, done}, '0);
        check("reset_data_in", {rdata, PWDATA, PADDR}, '0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("reset_ctrl_out", {PSEL, PENABLE, PWRITE, err, gnt, done}, '0);
        check("reset_data_out", {rdata, PWDATA, PADDR}, '0);

        // Single write from requester 2: SETUP, ACCESS, done on successive edges.
        issue(2, 32'h4, 32'hABCD, 1'b1, 1'b0, 1'b1);
        @(posedge PCLK); #1;
        check("t1_setup_phase", {PSEL, PENABLE, gnt}, {1'b1, 1'b0, 4'b0100});
        @(posedge PCLK); #1;
        check("t1_access_phase", {PSEL, PENABLE, gnt}, {1'b1, 1'b1, 4'b0100});
        @(posedge PCLK); #1;
        check("t1_done_phase", {PSEL, PENABLE, gnt, done}, {1'b0, 1'b0, 4'b0000, 4'b0100});
        @(negedge PCLK);
        req[2] = 1'b0;

        // Read back from requester 1.
        @(negedge PCLK);
        issue(1, 32'h4, 32'h0, 1'b0, 1'b0, 1'b1);
        wait_done(1, lat);
        req[1] = 1'b0;
        check("t2_latency", 96'(lat), 96'(3));

        // Three wait states and a slave error on the final cycle.
        fixed_waits = 3;
        @(negedge PCLK);
        issue(0, 32'hE000_0010, 32'h55AA, 1'b1, 1'b0, 1'b1);
        wait_done(0, lat);
        req[0] = 1'b0;
        check("t3_wait_latency", 96'(lat), 96'(6));
        fixed_waits = 0;

        // Reset during a stalled ACCESS: transfer is lost, no done.
        stall = 1'b1;
        @(negedge PCLK);
        issue(3, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!PENABLE && n < 10) begin
            @(negedge PCLK);
            n++;
        end
        check("t4_reached_access", 96'(PENABLE), 96'(1));
        @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        check("t4_reset_drop", {PSEL, PENABLE, gnt, done}, '0);
        req[3]     = 1'b0;
        pending[3] = 1'b0;
        repeat (3) @(negedge PCLK);
        check("t4_no_done", 96'(done), 96'(0));
        PRESETn = 1'b1;
        stall   = 1'b0;

        // All requesters held high: service order 0,1,2,3,0,... every 3 cycles.
        done_log.delete();
        @(negedge PCLK);
        fork
            rr_driver(0);
            rr_driver(1);
            rr_driver(2);
            rr_driver(3);
        join
        check("rr_count", 96'(done_log.size()), 96'(8));
        for (int k = 0; k < 8 && k < done_log.size(); k++) begin
            check($sformatf("rr_order_%0d", k), 96'(done_log[k].idx), 96'(k % N));
            if (k > 0) check($sformatf("rr_spacing_%0d", k),
                             96'(done_log[k].cyc - done_log[k-1].cyc), 96'(3));
        end

`ifdef APB_RR_MASTER_TIMEOUT_EN
        // Stuck slave: abandoned after TIMEOUT ACCESS cycles, then normal service.
        stall = 1'b1;
        @(negedge PCLK);
        issue(0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b1);
        wait_done(0, lat);
        req[0] = 1'b0;
        check("to_latency", 96'(lat), 96'(TIMEOUT + 2));
        stall = 1'b0;
        @(negedge PCLK);
        issue(0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b1);
        wait_done(0, lat);
        req[0] = 1'b0;
        check("to_next_latency", 96'(lat), 96'(3));
`endif

        // Randomized traffic with random wait states.
        fixed_waits = -1;
        @(negedge PCLK);
        fork
            rand_driver(0);
            rand_driver(1);
            rand_driver(2);
            rand_driver(3);
        join

        repeat (5) @(negedge PCLK);
        check("scoreboard_drained",
              96'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 96'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
